// File: rtl/regfile8x16_sb_if.sv
// rtl/regfile8x16_sb_if.sv - write-back, issue, read and scoreboard signals of the register file
interface regfile8x16_sb_if #(
    parameter int WIDTH = 16
);
    logic                 we;
    logic [2:0]           waddr;
    logic [WIDTH-1:0]     wdata;
    logic [2:0]           raddr_a;
    logic [2:0]           raddr_b;
    logic [WIDTH-1:0]     rdata_a;
    logic [WIDTH-1:0]     rdata_b;
    logic                 issue_en;
    logic [2:0]           issue_addr;
    logic                 busy_a;
    logic                 busy_b;
    logic                 stall;
    logic [7:0]           busy_vec;
    logic [8*WIDTH-1:0]   regs_flat;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, issue_en, issue_addr,
        input  rdata_a, rdata_b, busy_a, busy_b, stall, busy_vec, regs_flat
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, issue_en, issue_addr,
        output rdata_a, rdata_b, busy_a, busy_b, stall, busy_vec, regs_flat
    );
endinterface

// File: rtl/regfile8x16_sb.sv
// rtl/regfile8x16_sb.sv - 8-entry register file with per-register busy scoreboard
module regfile8x16_sb #(
    parameter int WIDTH   = 16,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    regfile8x16_sb_if.slave  rf
);
    localparam logic ZR = (ZERO_R0 != 0);
    localparam logic BP = (BYPASS != 0);

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic [7:0]       busy_q;
    logic [7:0]       busy_d;
    logic             wr_ok;

    assign wr_ok = rf.we && !(ZR && (rf.waddr == 3'd0));

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_ok) begin
            regs_d[rf.waddr] = rf.wdata;
        end
    end

    // A fresh issue outranks a write-back to the same index: the new producer still owes a result.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < 8; i++) begin
            if (rf.issue_en && (rf.issue_addr == 3'(i)) && !(ZR && (i == 0))) begin
                busy_d[i] = 1'b1;
            end else if (rf.we && (rf.waddr == 3'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rf.rdata_a = regs_q[rf.raddr_a];
        rf.busy_a  = busy_q[rf.raddr_a];
        if (ZR && (rf.raddr_a == 3'd0)) begin
            rf.rdata_a = '0;
            rf.busy_a  = 1'b0;
        end else if (BP && rf.we && (rf.waddr == rf.raddr_a)) begin
            rf.rdata_a = rf.wdata;
            rf.busy_a  = 1'b0;
        end
    end

    always_comb begin
        rf.rdata_b = regs_q[rf.raddr_b];
        rf.busy_b  = busy_q[rf.raddr_b];
        if (ZR && (rf.raddr_b == 3'd0)) begin
            rf.rdata_b = '0;
            rf.busy_b  = 1'b0;
        end else if (BP && rf.we && (rf.waddr == rf.raddr_b)) begin
            rf.rdata_b = rf.wdata;
            rf.busy_b  = 1'b0;
        end
    end

    assign rf.stall    = rf.busy_a | rf.busy_b;
    assign rf.busy_vec = busy_q;

    // The flat bus shows stored state only, never the forwarded write.
    for (genvar g = 0; g < 8; g++) begin : g_flat
        assign rf.regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
    end
endmodule

// File: tb/tb_regfile8x16_sb.sv
// tb/tb_regfile8x16_sb.sv - directed checks of regfile8x16_sb in three parameter configurations
module tb_regfile8x16_sb;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile8x16_sb_if #(.WIDTH(16)) if0 ();
    regfile8x16_sb_if #(.WIDTH(16)) if1 ();
    regfile8x16_sb_if #(.WIDTH(16)) if2 ();

    regfile8x16_sb #(.WIDTH(16), .ZERO_R0(0), .BYPASS(1)) dut0 (.clk(clk), .rst(rst), .rf(if0));
    regfile8x16_sb #(.WIDTH(16), .ZERO_R0(0), .BYPASS(0)) dut1 (.clk(clk), .rst(rst), .rf(if1));
    regfile8x16_sb #(.WIDTH(16), .ZERO_R0(1), .BYPASS(1)) dut2 (.clk(clk), .rst(rst), .rf(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic ie, input logic [2:0] ia);
        rst = r;
        if0.we = we; if0.waddr = wa; if0.wdata = wd; if0.raddr_a = ra; if0.raddr_b = rb;
        if0.issue_en = ie; if0.issue_addr = ia;
        if1.we = we; if1.waddr = wa; if1.wdata = wd; if1.raddr_a = ra; if1.raddr_b = rb;
        if1.issue_en = ie; if1.issue_addr = ia;
        if2.we = we; if2.waddr = wa; if2.wdata = wd; if2.raddr_a = ra; if2.raddr_b = rb;
        if2.issue_en = ie; if2.issue_addr = ia;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1, 0, 0, 16'h0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 16'h0, 0, 0, 0, 0);
        chk("rst_rdata_a", 128'(if0.rdata_a), 128'h0);
        chk("rst_busy_vec", 128'(if0.busy_vec), 128'h0);
        chk("rst_stall", 128'(if0.stall), 128'h0);
        chk("rst_flat", if0.regs_flat, 128'h0);

        // write r3, read it on both ports next cycle
        drive(0, 1, 3, 16'hA5A5, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 16'h0, 3, 3, 0, 0);
        chk("wr_rdata_a", 128'(if0.rdata_a), 128'hA5A5);
        chk("wr_rdata_b", 128'(if0.rdata_b), 128'hA5A5);
        chk("wr_flat0", if0.regs_flat, {64'h0, 16'hA5A5, 48'h0});
        chk("wr_flat2", if2.regs_flat, {64'h0, 16'hA5A5, 48'h0});

        // same-cycle forwarding
        drive(0, 1, 5, 16'h1234, 5, 3, 0, 0);
        chk("byp_on", 128'(if0.rdata_a), 128'h1234);
        chk("byp_off", 128'(if1.rdata_a), 128'h0);
        chk("byp_flat", if0.regs_flat, {64'h0, 16'hA5A5, 48'h0});
        tick();
        drive(0, 0, 0, 16'h0, 5, 3, 0, 0);
        chk("byp_after", 128'(if1.rdata_a), 128'h1234);

        // issue r2 then write it back
        drive(0, 0, 0, 16'h0, 0, 0, 1, 2);
        tick();
        drive(0, 0, 0, 16'h0, 2, 0, 0, 0);
        chk("iss_busy_a", 128'(if0.busy_a), 128'h1);
        chk("iss_stall", 128'(if0.stall), 128'h1);
        chk("iss_vec", 128'(if0.busy_vec), 128'h04);
        chk("iss_busy_b", 128'(if0.busy_b), 128'h0);
        drive(0, 0, 0, 16'h0, 0, 2, 0, 0);
        chk("iss_stall_b", 128'(if0.stall), 128'h1);
        drive(0, 1, 2, 16'h00FF, 2, 0, 0, 0);
        chk("wb_busy_a_byp", 128'(if0.busy_a), 128'h0);
        chk("wb_stall_byp", 128'(if0.stall), 128'h0);
        chk("wb_busy_a_nobyp", 128'(if1.busy_a), 128'h1);
        tick();
        drive(0, 0, 0, 16'h0, 2, 0, 0, 0);
        chk("wb_vec", 128'(if0.busy_vec), 128'h0);
        chk("wb_vec_nobyp", 128'(if1.busy_vec), 128'h0);
        chk("wb_rdata", 128'(if1.rdata_a), 128'h00FF);

        // issue r6, then issue and write r6 together
        drive(0, 0, 0, 16'h0, 0, 0, 1, 6);
        tick();
        drive(0, 1, 6, 16'hBEEF, 0, 0, 1, 6);
        tick();
        drive(0, 0, 0, 16'h0, 6, 0, 0, 0);
        chk("coll_vec", 128'(if0.busy_vec), 128'h40);
        chk("coll_busy_a", 128'(if0.busy_a), 128'h1);
        chk("coll_r6", 128'(if0.regs_flat[111:96]), 128'hBEEF);

        // write and issue r0
        drive(0, 1, 0, 16'hFFFF, 0, 0, 1, 0);
        chk("z_rdata", 128'(if2.rdata_a), 128'h0);
        chk("nz_rdata", 128'(if0.rdata_a), 128'hFFFF);
        tick();
        drive(0, 0, 0, 16'h0, 0, 0, 0, 0);
        chk("z_vec", 128'(if2.busy_vec), 128'h40);
        chk("z_flat", 128'(if2.regs_flat[15:0]), 128'h0);
        chk("z_busy_a", 128'(if2.busy_a), 128'h0);
        chk("nz_vec", 128'(if0.busy_vec), 128'h41);
        chk("nz_flat", 128'(if0.regs_flat[15:0]), 128'hFFFF);
        chk("nz_busy_a", 128'(if0.busy_a), 128'h1);

        // reset discards reservations and the concurrent write
        drive(0, 1, 1, 16'h0001, 0, 0, 1, 4);
        tick();
        drive(0, 0, 0, 16'h0, 1, 4, 0, 0);
        chk("pre_rst_vec", 128'(if0.busy_vec), 128'h51);
        chk("pre_rst_r1", 128'(if0.rdata_a), 128'h0001);
        drive(1, 1, 7, 16'h7777, 7, 4, 1, 3);
        tick();
        drive(0, 0, 0, 16'h0, 7, 4, 0, 0);
        chk("post_rst_flat0", if0.regs_flat, 128'h0);
        chk("post_rst_flat2", if2.regs_flat, 128'h0);
        chk("post_rst_vec", 128'(if0.busy_vec), 128'h0);
        chk("post_rst_r7", 128'(if0.rdata_a), 128'h0);
        chk("post_rst_stall", 128'(if0.stall), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
